// File: rtl/fifo_reader_pkg.sv
// fifo_reader shared types: holding-buffer depth and occupancy encoding.
package fifo_reader_pkg;

    localparam int unsigned BUF_DEPTH = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry holding buffer that absorbs the fifo's pop-to-data latency.
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output occ_t             occ,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (clr) begin
            occ    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (rd_en) rd_ptr <= ~rd_ptr;
            occ <= occ + occ_t'(wr_en) - occ_t'(rd_en);
        end
    end

    // Storage needs no reset; occ gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Drains a fifo into a full-rate valid/ready stream and counts deliveries.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16,
    parameter int DEBUG     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 fifo_pop,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 fifo_empty,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0] delivered
);

    if (DEBUG < 0 || DEBUG > 1) begin : g_bad_debug
        $error("fifo_reader: DEBUG must be 0 or 1");
    end

    occ_t       occ;
    logic       inflight;
    logic       deq;
    logic       capture;
    logic [2:0] load;

    assign out_valid = (occ != '0) && !flush;
    assign deq       = out_valid && out_ready;
    assign capture   = inflight && !flush;

    // Words already owed to the buffer; a same-cycle deq frees one slot.
    assign load     = {1'b0, occ} + {2'b00, inflight};
    assign fifo_pop = !fifo_empty && !flush && rst_n
                    && (load < (3'(BUF_DEPTH) + {2'b00, deq}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            delivered <= '0;
        end else begin
            inflight <= fifo_pop;
            if (deq) delivered <= delivered + 1'b1;
        end
    end

    fifo_reader_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (flush),
        .wr_en  (capture),
        .wr_data(fifo_data),
        .rd_en  (deq),
        .occ    (occ),
        .rd_data(out_data)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a queue-based fifo and stream model.
module tb_fifo_reader;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_pop;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] delivered;

    always #5 clk = ~clk;

    fifo_reader #(
        .WIDTH(W),
        .CNT_WIDTH(CW),
        .DEBUG(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_pop  (fifo_pop),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .delivered (delivered)
    );

    int tests = 0;
    int fails = 0;

    logic [W-1:0]  fq[$];
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  got[$];
    logic [CW-1:0] mcnt = '0;
    int            pops = 0;
    int            delivs = 0;

    logic          obs_pop;
    logic          obs_valid;
    logic          obs_deq;
    logic [W-1:0]  obs_data;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One clock: compare at negedge, then advance the fifo model.
    task automatic cyc();
        @(negedge clk);
        obs_pop   = fifo_pop;
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_deq   = out_valid && out_ready;
        if (!rst_n) begin
            pops   = 0;
            delivs = 0;
            mcnt   = '0;
        end else begin
            chk("delivered", 32'(delivered), 32'(mcnt));
            if (obs_valid) begin
                if (exp_q.size() == 0)
                    chk("spurious_valid", 32'(obs_data), 32'hFFFF_FFFF);
                else
                    chk("head_data", 32'(obs_data), 32'(exp_q[0]));
            end
            if (obs_deq) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                mcnt = mcnt + 1'b1;
                delivs++;
                got.push_back(obs_data);
            end
            if (obs_pop) pops++;
            if (flush) begin
                pops   = 0;
                delivs = 0;
            end
            chk("outstanding_le_2", 32'(pops - delivs <= 2), 32'd1);
        end
        @(posedge clk);
        #1;
        if (obs_pop && fq.size() != 0) fifo_data = fq.pop_front();
        if (flush) fq.delete();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic push(input logic [W-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fq.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        got.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_pop;
        int first_val;
        int last_val;
        int npop;
        int ndeq;
        bit seen;

        cyc();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_pop", 32'(fifo_pop), 32'd0);
        chk("reset_delivered", 32'(delivered), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Basic drain
        got.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(W'(i));
        first_pop = -1;
        first_val = -1;
        last_val  = -1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (obs_pop && first_pop < 0) first_pop = c;
            if (obs_deq) begin
                if (first_val < 0) first_val = c;
                last_val = c;
            end
        end
        chk("drain_latency", 32'(first_val - first_pop), 32'd2);
        chk("drain_span", 32'(last_val - first_val), 32'd3);
        chk("drain_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("drain_w0", 32'(got[0]), 32'h0001);
            chk("drain_w3", 32'(got[3]), 32'h0004);
        end
        chk("drain_delivered", 32'(delivered), 32'd4);

        // Backpressure
        got.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(W'(16'h00A0 + i));
        npop = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (obs_pop) npop++;
        end
        chk("bp_pops", 32'(npop), 32'd2);
        chk("bp_pop_held", 32'(obs_pop), 32'd0);
        chk("bp_valid", 32'(obs_valid), 32'd1);
        chk("bp_head", 32'(obs_data), 32'h00A0);
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) cyc();
        chk("bp_count", 32'(got.size()), 32'd8);
        if (got.size() == 8) begin
            chk("bp_first", 32'(got[0]), 32'h00A0);
            chk("bp_last", 32'(got[7]), 32'h00A7);
        end
        chk("bp_delivered", 32'(delivered), 32'd12);

        // Alternating ready
        got.delete();
        for (int i = 0; i < 6; i++) push(W'(16'h0100 + i));
        for (int c = 0; c < 30; c++) begin
            out_ready = c[0];
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("alt_count", 32'(got.size()), 32'd6);
        if (got.size() == 6) chk("alt_last", 32'(got[5]), 32'h0105);
        chk("alt_delivered", 32'(delivered), 32'd2);

        // Flush with a pop in flight
        got.delete();
        push(16'h00FF);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            cyc();
            seen = obs_pop;
        end
        chk("flush_pop_seen", 32'(seen), 32'd1);
        flush = 1'b1;
        exp_q.delete();
        cyc();
        chk("flush_cycle_valid", 32'(obs_valid), 32'd0);
        chk("flush_cycle_pop", 32'(obs_pop), 32'd0);
        flush = 1'b0;
        cyc();
        chk("post_flush_valid", 32'(obs_valid), 32'd0);
        for (int c = 0; c < 4; c++) cyc();
        chk("flush_no_ff", 32'(got.size()), 32'd0);
        chk("flush_delivered", 32'(delivered), 32'd2);

        // Asynchronous reset with a full buffer
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(W'(16'h0300 + i));
        for (int c = 0; c < 6; c++) cyc();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_now", 32'(out_valid), 32'd0);
        chk("rst_pop_now", 32'(fifo_pop), 32'd0);
        chk("rst_delivered_now", 32'(delivered), 32'd0);
        do_reset();
        out_ready = 1'b1;
        push(16'h0200);
        push(16'h0201);
        for (int c = 0; c < 8; c++) cyc();
        chk("rst_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("rst_w0", 32'(got[0]), 32'h0200);
            chk("rst_w1", 32'(got[1]), 32'h0201);
        end
        chk("rst_delivered", 32'(delivered), 32'd2);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 17; i++) push(W'(16'h0400 + i));
        ndeq = 0;
        for (int c = 0; c < 25; c++) begin
            cyc();
            if (obs_deq) ndeq++;
        end
        chk("wrap_count", 32'(ndeq), 32'd17);
        chk("wrap_delivered", 32'(delivered), 32'd1);
        chk("all_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
